// File: rtl/vc_output_scheduler_if.sv
// Bundle between the VC buffers / downstream link and vc_output_scheduler.
//   vc_req_i    : head flit of each VC buffer, VC v at [v*FLIT_W +: FLIT_W]
//   vc_ready_o  : one-hot pop strobe back to the VC buffers
//   fout_req_o  : registered outgoing flit
//   fout_resp_i : downstream ready
//   credit_i    : per-VC credit return pulse
//   lock_o      : a packet currently owns the output link
//   lock_vc_o   : VC owning the output link
//   err_o       : sticky protocol/credit error
// master = scheduler side, slave = buffers/link side.
interface vc_output_scheduler_if #(
    parameter int unsigned N_VC   = 3,
    parameter int unsigned FLIT_W = 37
);
    logic [N_VC*FLIT_W-1:0] vc_req_i;
    logic [N_VC-1:0]        vc_ready_o;
    logic [FLIT_W-1:0]      fout_req_o;
    logic                   fout_resp_i;
    logic [N_VC-1:0]        credit_i;
    logic                   lock_o;
    logic [1:0]             lock_vc_o;
    logic                   err_o;

    modport master (
        input  vc_req_i, fout_resp_i, credit_i,
        output vc_ready_o, fout_req_o, lock_o, lock_vc_o, err_o
    );

    modport slave (
        output vc_req_i, fout_resp_i, credit_i,
        input  vc_ready_o, fout_req_o, lock_o, lock_vc_o, err_o
    );
endinterface

// File: rtl/vc_output_scheduler.sv
// Output-side scheduler: round-robin picks one VC buffer for the single
// output link, locks the link from head to tail flit, gates on per-VC
// downstream credits and registers the chosen flit.
// Ports:
//   clk  : clock, rising edge
//   arst : asynchronous active-low reset
//   bus  : vc_output_scheduler_if.master (see interface for signal list)
module vc_output_scheduler #(
    parameter int unsigned N_VC      = 3,
    parameter int unsigned FLIT_W    = 37,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    vc_output_scheduler_if.master bus
);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [1:0] T_SINGLE = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_BODY   = 2'b10;
    localparam logic [1:0] T_TAIL   = 2'b11;

    logic [0:0]        state_q,   state_d;
    logic [1:0]        rr_ptr_q,  rr_ptr_d;
    logic [1:0]        lock_vc_q, lock_vc_d;
    logic [FLIT_W-1:0] fout_q,    fout_d;
    logic              err_q,     err_d;
    logic [CW-1:0]     credit_q [N_VC];
    logic [CW-1:0]     credit_d [N_VC];

    logic              out_free_c;
    logic [N_VC-1:0]   cand_c;
    logic              pop_c;
    logic              fwd_c;
    logic [1:0]        pop_vc_c;
    logic [FLIT_W-1:0] sel_flit_c;
    logic [1:0]        sel_type_c;
    logic [N_VC-1:0]   ready_c;

    // Arbitration, lock tracking, output register and credit next-state.
    always_comb begin
        int unsigned idx;
        logic        dec;
        logic        inc;

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_vc_d  = lock_vc_q;
        fout_d     = fout_q;
        err_d      = err_q;
        pop_c      = 1'b0;
        fwd_c      = 1'b0;
        pop_vc_c   = 2'b00;
        sel_flit_c = '0;
        sel_type_c = 2'b00;
        ready_c    = '0;
        idx        = 0;
        dec        = 1'b0;
        inc        = 1'b0;

        out_free_c = !fout_q[0] || bus.fout_resp_i;

        // Nothing may pop while reset is held, even though state is at reset values.
        for (int unsigned v = 0; v < N_VC; v++) begin
            cand_c[v] = arst && out_free_c && bus.vc_req_i[v*FLIT_W]
                        && (credit_q[v] != '0);
        end

        if (state_q == ST_IDLE) begin
            // First candidate scanning upward from rr_ptr+1 with wrap.
            for (int unsigned i = 1; i <= N_VC; i++) begin
                idx = (32'(rr_ptr_q) + i) % N_VC;
                for (int unsigned v = 0; v < N_VC; v++) begin
                    if (!pop_c && (v == idx) && cand_c[v]) begin
                        pop_c    = 1'b1;
                        pop_vc_c = 2'(v);
                    end
                end
            end
        end else begin
            for (int unsigned v = 0; v < N_VC; v++) begin
                if ((lock_vc_q == 2'(v)) && cand_c[v]) begin
                    pop_c    = 1'b1;
                    pop_vc_c = 2'(v);
                end
            end
        end

        for (int unsigned v = 0; v < N_VC; v++) begin
            if (pop_vc_c == 2'(v)) begin
                sel_flit_c = bus.vc_req_i[v*FLIT_W +: FLIT_W];
                ready_c[v] = pop_c;
            end
        end
        sel_type_c = sel_flit_c[FLIT_W-1 -: 2];

        if (pop_c) begin
            if (state_q == ST_IDLE) begin
                case (sel_type_c)
                    T_SINGLE: begin
                        fwd_c    = 1'b1;
                        rr_ptr_d = pop_vc_c;
                    end
                    T_HEAD: begin
                        fwd_c     = 1'b1;
                        state_d   = ST_LOCKED;
                        lock_vc_d = pop_vc_c;
                    end
                    // Orphan body/tail: drop it, keep arbitration order.
                    default: err_d = 1'b1;
                endcase
            end else begin
                case (sel_type_c)
                    T_BODY: fwd_c = 1'b1;
                    T_TAIL: begin
                        fwd_c    = 1'b1;
                        state_d  = ST_IDLE;
                        rr_ptr_d = lock_vc_q;
                    end
                    // New packet start inside a packet closes the current one.
                    default: begin
                        fwd_c    = 1'b1;
                        err_d    = 1'b1;
                        state_d  = ST_IDLE;
                        rr_ptr_d = lock_vc_q;
                    end
                endcase
            end
        end

        if (fwd_c) begin
            fout_d      = sel_flit_c;
            fout_d[2:1] = pop_vc_c;
        end else if (bus.fout_resp_i) begin
            fout_d[0] = 1'b0;
        end

        // Simultaneous pop and return cancel; overflow returns are dropped.
        for (int unsigned v = 0; v < N_VC; v++) begin
            dec         = fwd_c && (pop_vc_c == 2'(v));
            inc         = bus.credit_i[v];
            credit_d[v] = credit_q[v];
            if (dec && !inc) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (!dec && inc) begin
                if (credit_q[v] == CW'(BUF_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 2'(N_VC - 1);
            lock_vc_q <= 2'b00;
            fout_q    <= '0;
            err_q     <= 1'b0;
            for (int unsigned v = 0; v < N_VC; v++) begin
                credit_q[v] <= CW'(BUF_DEPTH);
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_vc_q <= lock_vc_d;
            fout_q    <= fout_d;
            err_q     <= err_d;
            for (int unsigned v = 0; v < N_VC; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    assign bus.vc_ready_o = ready_c;
    assign bus.fout_req_o = fout_q;
    assign bus.lock_o     = (state_q == ST_LOCKED);
    assign bus.lock_vc_o  = lock_vc_q;
    assign bus.err_o      = err_q;

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Directed bench for vc_output_scheduler: inputs driven 1 time unit after
// the rising edge, combinational pop strobes checked 1 unit later, registered
// outputs checked after the following edge.
module tb_vc_output_scheduler;
    localparam int unsigned N_VC      = 3;
    localparam int unsigned FLIT_W    = 37;
    localparam int unsigned BUF_DEPTH = 4;

    logic clk = 1'b0;
    logic arst;

    always #5 clk = ~clk;

    vc_output_scheduler_if #(.N_VC(N_VC), .FLIT_W(FLIT_W)) bus ();

    vc_output_scheduler #(
        .N_VC(N_VC), .FLIT_W(FLIT_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flit with given type and payload, valid set, vc_id 0.
    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [31:0] p);
        return {t, p, 2'b00, 1'b1};
    endfunction

    // Flit as it must appear on the output after coming from VC vc.
    function automatic logic [FLIT_W-1:0] on_link(input logic [FLIT_W-1:0] f, input logic [1:0] vc);
        logic [FLIT_W-1:0] r;
        r      = f;
        r[2:1] = vc;
        return r;
    endfunction

    task automatic setvc(input int unsigned v, input logic [FLIT_W-1:0] f);
        bus.vc_req_i[v*FLIT_W +: FLIT_W] = f;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        bus.vc_req_i    = '0;
        bus.credit_i    = '0;
        bus.fout_resp_i = 1'b1;
        arst            = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b1;
    endtask

    logic [FLIT_W-1:0] fa, fb, fc, fh;
    logic [2:0]        gseq [6];

    initial begin
        // Reset values while reset is held
        bus.vc_req_i    = '0;
        bus.credit_i    = '0;
        bus.fout_resp_i = 1'b1;
        arst            = 1'b0;
        #2;
        chk("rst_fout",    64'(bus.fout_req_o), 64'h0);
        chk("rst_ready",   64'(bus.vc_ready_o), 64'h0);
        chk("rst_lock",    64'(bus.lock_o),     64'h0);
        chk("rst_lock_vc", 64'(bus.lock_vc_o),  64'h0);
        chk("rst_err",     64'(bus.err_o),      64'h0);

        // Single-flit packet from VC1
        do_reset();
        fa = mk(2'b00, 32'h1234);
        setvc(1, fa);
        #1 chk("t1_ready", 64'(bus.vc_ready_o), 64'h2);
        cyc();
        setvc(1, '0);
        #1;
        chk("t1_ready_off", 64'(bus.vc_ready_o), 64'h0);
        chk("t1_fout",      64'(bus.fout_req_o), 64'(on_link(fa, 2'd1)));
        chk("t1_credit1",   64'(dut.credit_q[1]), 64'd3);
        cyc();
        #1 chk("t1_fout_clr", 64'(bus.fout_req_o[0]), 64'h0);

        // Round-robin among three always-valid VCs
        do_reset();
        for (int v = 0; v < 3; v++) setvc(v, mk(2'b00, 32'hA0 + v));
        gseq[0] = 3'b001; gseq[1] = 3'b010; gseq[2] = 3'b100;
        gseq[3] = 3'b001; gseq[4] = 3'b010; gseq[5] = 3'b100;
        for (int i = 0; i < 6; i++) begin
            #1 chk("t2_grant", 64'(bus.vc_ready_o), 64'(gseq[i]));
            cyc();
            chk("t2_fout", 64'(bus.fout_req_o),
                64'(on_link(mk(2'b00, 32'hA0 + (i % 3)), 2'(i % 3))));
        end

        // Wormhole lock on VC0 while VC2 waits
        do_reset();
        setvc(2, mk(2'b00, 32'hC2));
        setvc(0, mk(2'b01, 32'h10));
        #1;
        chk("t3_head_ready", 64'(bus.vc_ready_o), 64'h1);
        chk("t3_lock0",      64'(bus.lock_o),     64'h0);
        cyc();
        setvc(0, mk(2'b10, 32'h11));
        #1;
        chk("t3_body_ready", 64'(bus.vc_ready_o), 64'h1);
        chk("t3_lock1",      64'(bus.lock_o),     64'h1);
        chk("t3_lock_vc",    64'(bus.lock_vc_o),  64'h0);
        cyc();
        fh = mk(2'b11, 32'h12);
        setvc(0, fh);
        #1;
        chk("t3_tail_ready", 64'(bus.vc_ready_o), 64'h1);
        chk("t3_lock2",      64'(bus.lock_o),     64'h1);
        cyc();
        setvc(0, '0);
        #1;
        chk("t3_vc2_ready", 64'(bus.vc_ready_o), 64'h4);
        chk("t3_lock3",     64'(bus.lock_o),     64'h0);
        chk("t3_tail_out",  64'(bus.fout_req_o), 64'(on_link(fh, 2'd0)));
        cyc();
        setvc(2, '0);

        // Credit exhaustion on VC0 and a single credit return
        do_reset();
        fa = mk(2'b00, 32'h55);
        setvc(0, fa);
        for (int i = 0; i < 5; i++) begin
            #1 chk("t4_ready", 64'(bus.vc_ready_o), (i < 4) ? 64'h1 : 64'h0);
            cyc();
        end
        bus.credit_i = 3'b001;
        #1;
        chk("t4_blocked",   64'(bus.vc_ready_o),    64'h0);
        chk("t4_fout_idle", 64'(bus.fout_req_o[0]), 64'h0);
        cyc();
        bus.credit_i = 3'b000;
        #1 chk("t4_fifth_ready", 64'(bus.vc_ready_o), 64'h1);
        cyc();
        chk("t4_fifth_out", 64'(bus.fout_req_o), 64'(on_link(fa, 2'd0)));
        chk("t4_no_err",    64'(bus.err_o),      64'h0);

        // Downstream stall holds the output and blocks pops
        do_reset();
        fa = mk(2'b00, 32'hAA);
        fb = mk(2'b00, 32'hBB);
        fc = mk(2'b00, 32'hCC);
        setvc(1, fa);
        #1 chk("t5_first_ready", 64'(bus.vc_ready_o), 64'h2);
        cyc();
        bus.fout_resp_i = 1'b0;
        setvc(1, fb);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_stall_ready", 64'(bus.vc_ready_o), 64'h0);
            chk("t5_stall_hold",  64'(bus.fout_req_o), 64'(on_link(fa, 2'd1)));
            cyc();
        end
        bus.fout_resp_i = 1'b1;
        #1 chk("t5_resume_ready", 64'(bus.vc_ready_o), 64'h2);
        cyc();
        setvc(1, fc);
        #1;
        chk("t5_out_b",   64'(bus.fout_req_o), 64'(on_link(fb, 2'd1)));
        chk("t5_ready_c", 64'(bus.vc_ready_o), 64'h2);
        cyc();
        chk("t5_out_c", 64'(bus.fout_req_o), 64'(on_link(fc, 2'd1)));

        // Orphan body flit, sticky error, then reset mid-packet
        do_reset();
        setvc(2, mk(2'b10, 32'hBD));
        #1 chk("t6_orphan_pop", 64'(bus.vc_ready_o), 64'h4);
        cyc();
        setvc(2, '0);
        #1;
        chk("t6_err",       64'(bus.err_o),         64'h1);
        chk("t6_not_fwd",   64'(bus.fout_req_o[0]), 64'h0);
        cyc();
        #1 chk("t6_err_sticky", 64'(bus.err_o), 64'h1);
        setvc(1, mk(2'b01, 32'h70));
        #1 chk("t6_head_ready", 64'(bus.vc_ready_o), 64'h2);
        cyc();
        setvc(1, mk(2'b10, 32'h71));
        #1;
        chk("t6_locked",  64'(bus.lock_o),    64'h1);
        chk("t6_lock_vc", 64'(bus.lock_vc_o), 64'h1);
        arst = 1'b0;
        #1;
        chk("t6_rst_lock",    64'(bus.lock_o),     64'h0);
        chk("t6_rst_lock_vc", 64'(bus.lock_vc_o),  64'h0);
        chk("t6_rst_err",     64'(bus.err_o),      64'h0);
        chk("t6_rst_fout",    64'(bus.fout_req_o), 64'h0);
        chk("t6_rst_ready",   64'(bus.vc_ready_o), 64'h0);

        // Credit return while already at full count
        do_reset();
        bus.credit_i = 3'b010;
        cyc();
        bus.credit_i = 3'b000;
        #1;
        chk("t7_overflow_err", 64'(bus.err_o),         64'h1);
        chk("t7_credit_cap",   64'(dut.credit_q[1]),   64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
